uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL provide parameter CLOCK_FREQ, default 50_000_000, system clock in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL provide parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL provide parameter PARITY, default 0, where 0 = none, 1 = odd and 2 = even.
REQ-005 SHALL provide parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-006 SHALL provide port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL provide port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL provide port uart_rx, input, 1 bit, asynchronous serial line that idles high.
REQ-009 SHALL provide port rx_data, output, DATA_BITS wide, last received word with bit 0 received first.
REQ-010 SHALL provide port rx_done, output, 1 bit, one-cycle pulse marking frame completion.
REQ-011 SHALL provide port parity_err, output, 1 bit, parity mismatch for the last frame; constant 0 when PARITY=0.
REQ-012 SHALL provide port frame_err, output, 1 bit, a stop bit sampled low in the last frame.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer plus one delay flop, and detect a falling edge as delayed=1 and synchronized=0.
REQ-014 SHALL derive BAUD_DIV = CLOCK_FREQ/BAUD using integer division and run the bit counter 0..BAUD_DIV-1, wrapping to 0.
REQ-015 SHALL form each bit value by 2-of-3 majority vote over synchronized samples taken at bit counter values MID-1, MID and MID+1, where MID = BAUD_DIV/2.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL leave IDLE for START only on a falling edge; the bit counter is cleared to 0 in that cycle.
REQ-018 SHALL, in START, return to IDLE without rx_done or error flags when the voted start bit is 1 (glitch rejection); otherwise it moves to DATA at counter wrap.
REQ-019 SHALL, in DATA, shift in exactly DATA_BITS voted bits LSB first, then go to PARITY if PARITY≠0, else to STOP.
REQ-020 SHALL, in PARITY, compare the voted bit with XOR of the data bits (inverted for odd parity), with the mismatch held internally until frame end.
REQ-021 SHALL, in STOP, vote each of STOP_BITS bits; any voted 0 sets the internal frame-error flag.
REQ-022 SHALL, in the cycle after the MID+1 sample of the final stop bit, pulse rx_done high for exactly 1 cycle; rx_data, parity_err and frame_err update in that same cycle and hold until the next rx_done; the FSM returns to IDLE in that cycle.
REQ-023 SHALL ignore falling edges outside IDLE; a falling edge occurring in the cycle the FSM enters IDLE is not missed, giving half-bit resynchronisation for back-to-back frames.
REQ-024 SHALL report a line held low (break) as a frame with rx_data=0 and frame_err=1 (parity_err per parity rule), and shall start no further frame until the line returns high and falls again.
REQ-025 SHALL never change rx_data or the error flags except on rx_done.

Reset
REQ-026 SHALL, while reset is high, force FSM=IDLE, counters=0, rx_data=0, rx_done=0, parity_err=0, frame_err=0, and set the synchronizer flops to 1 (idle line).
REQ-027 SHALL abandon an in-progress frame when reset is asserted mid-frame, without emitting rx_done for it after release.

Verification
REQ-028 SHALL verify that with defaults (8N1), sending 0xA5 produces one rx_done pulse, rx_data=8'hA5 and both flags 0.
REQ-029 SHALL verify that with PARITY=2, sending 0x3C with parity bit 1 gives rx_done, rx_data=8'h3C and parity_err=1; a following frame with correct parity clears it to 0.
REQ-030 SHALL verify that 0x55 with its stop bit driven 0 gives rx_done, rx_data=8'h55 and frame_err=1.
REQ-031 SHALL verify that a low glitch lasting BAUD_DIV/4 cycles on the idle line gives no rx_done and unchanged outputs.
REQ-032 SHALL verify that with DATA_BITS=7 and STOP_BITS=2, frames 0x41 and 0x7F sent back-to-back with no idle gap give two rx_done pulses in order with rx_data 7'h41 then 7'h7F.
REQ-033 SHALL verify that reset asserted at data bit 4 of a frame gives all outputs 0 and no rx_done, and that the next full frame 0x0F is then received correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// UART frame receiver: synchronised line, 3-sample majority vote per bit,
// optional parity and 1 or 2 stop bits; results are published only on rx_done.
module uart_frame_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
  localparam int MID      = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(MID + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync1_reg, sync2_reg, delay_reg;
  logic [2:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic [1:0]           samp_reg, samp_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_err_reg, par_err_next;
  logic                 frm_err_reg, frm_err_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_done_reg, rx_done_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;

  logic fall_edge;
  logic cnt_wrap;
  logic at_s2;
  logic vote;
  logic parity_exp;
  logic stop_err;

  assign fall_edge  = delay_reg & ~sync2_reg;
  assign cnt_wrap   = (cnt_reg == CNT_LAST);
  assign at_s2      = (cnt_reg == CNT_S2);
  // Third sample is taken live from the synchroniser in the MID+1 cycle.
  assign vote       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & sync2_reg) |
                      (samp_reg[1] & sync2_reg);
  assign parity_exp = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);
  assign stop_err   = frm_err_reg | ~vote;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_wrap ? '0 : cnt_reg + 1'b1;
    idx_next        = idx_reg;
    stop_idx_next   = stop_idx_reg;
    samp_next       = samp_reg;
    shift_next      = shift_reg;
    par_err_next    = par_err_reg;
    frm_err_next    = frm_err_reg;
    rx_data_next    = rx_data_reg;
    rx_done_next    = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;

    if (cnt_reg == CNT_S0) samp_next[0] = sync2_reg;
    if (cnt_reg == CNT_S1) samp_next[1] = sync2_reg;

    case (state_reg)
      S_IDLE: begin
        cnt_next      = '0;
        idx_next      = '0;
        stop_idx_next = 1'b0;
        if (fall_edge) begin
          state_next   = S_START;
          par_err_next = 1'b0;
          frm_err_next = 1'b0;
        end
      end
      S_START: begin
        if (at_s2 && vote) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_wrap) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (at_s2) shift_next = {vote, shift_reg[DATA_BITS-1:1]};
        if (cnt_wrap) begin
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_s2) par_err_next = vote ^ parity_exp;
        if (cnt_wrap) state_next = S_STOP;
      end
      S_STOP: begin
        if (at_s2) begin
          frm_err_next = stop_err;
          if (stop_idx_reg == STOP_LAST) begin
            // Publish everything together; registered, so it appears next cycle.
            state_next      = S_IDLE;
            cnt_next        = '0;
            rx_done_next    = 1'b1;
            rx_data_next    = shift_reg;
            parity_err_next = par_err_reg;
            frame_err_next  = stop_err;
          end
        end else if (cnt_wrap) begin
          stop_idx_next = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      delay_reg      <= 1'b1;
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      stop_idx_reg   <= 1'b0;
      samp_reg       <= '0;
      shift_reg      <= '0;
      par_err_reg    <= 1'b0;
      frm_err_reg    <= 1'b0;
      rx_data_reg    <= '0;
      rx_done_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sync1_reg      <= uart_rx;
      sync2_reg      <= sync1_reg;
      delay_reg      <= sync2_reg;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      stop_idx_reg   <= stop_idx_next;
      samp_reg       <= samp_next;
      shift_reg      <= shift_next;
      par_err_reg    <= par_err_next;
      frm_err_reg    <= frm_err_next;
      rx_data_reg    <= rx_data_next;
      rx_done_reg    <= rx_done_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_done    = rx_done_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three instances (8N1, 8E1, 7N2) fed by a bit-level
// transmitter; expected frames are queued on send and compared on rx_done.
module tb_uart_frame_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD_R = 100_000;
  localparam int BD     = CLK_HZ / BAUD_R;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic done_a, done_b, done_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t ea, eb, ec;
  int   np_a = 0, np_b = 0, np_c = 0;
  int   nd_a = 0, nd_b = 0, nd_c = 0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD_R)) u_a (
    .clk(clk), .reset(reset), .uart_rx(rx_a), .rx_data(data_a),
    .rx_done(done_a), .parity_err(perr_a), .frame_err(ferr_a));

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD_R), .PARITY(2)) u_b (
    .clk(clk), .reset(reset), .uart_rx(rx_b), .rx_data(data_b),
    .rx_done(done_b), .parity_err(perr_b), .frame_err(ferr_b));

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .uart_rx(rx_c), .rx_data(data_c),
    .rx_done(done_c), .parity_err(perr_c), .frame_err(ferr_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int inst, input logic v);
    @(negedge clk);
    set_line(inst, v);
    repeat (BD - 1) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0: begin q_a.push_back(e); np_a++; end
      1: begin q_b.push_back(e); np_b++; end
      default: begin q_c.push_back(e); np_c++; end
    endcase
  endtask

  // has_par: send a parity bit; expectation assumes even parity on that instance
  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input int nstop,
                            input logic stop0);
    logic [8:0] d;
    exp_t e;
    d = data & 9'((1 << nbits) - 1);
    e.data = d;
    e.perr = has_par ? (par_bit != (^d)) : 1'b0;
    e.ferr = ~stop0;
    push_exp(inst, e);
    $display("send inst=%0d data=%0h par=%0b/%0b stop0=%0b", inst, d, has_par, par_bit, stop0);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(inst, d[i]);
    if (has_par) drive_bit(inst, par_bit);
    drive_bit(inst, stop0);
    for (int i = 1; i < nstop; i++) drive_bit(inst, 1'b1);
    set_line(inst, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset && done_a) begin
      nd_a++;
      chk("a_pending", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        $display("rx inst=0 data=%0h perr=%0b ferr=%0b", data_a, perr_a, ferr_a);
        chk("a_data", 32'(data_a), 32'(ea.data));
        chk("a_perr", 32'(perr_a), 32'(ea.perr));
        chk("a_ferr", 32'(ferr_a), 32'(ea.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done_b) begin
      nd_b++;
      chk("b_pending", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        $display("rx inst=1 data=%0h perr=%0b ferr=%0b", data_b, perr_b, ferr_b);
        chk("b_data", 32'(data_b), 32'(eb.data));
        chk("b_perr", 32'(perr_b), 32'(eb.perr));
        chk("b_ferr", 32'(ferr_b), 32'(eb.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done_c) begin
      nd_c++;
      chk("c_pending", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) begin
        ec = q_c.pop_front();
        $display("rx inst=2 data=%0h perr=%0b ferr=%0b", data_c, perr_c, ferr_c);
        chk("c_data", 32'(data_c), 32'(ec.data));
        chk("c_perr", 32'(perr_c), 32'(ec.perr));
        chk("c_ferr", 32'(ferr_c), 32'(ec.ferr));
      end
    end
  end

  initial begin
    logic [7:0] partial;
    int saved;

    idle(3);
    chk("rst_data_a", 32'(data_a), 0);
    chk("rst_flags_a", {29'd0, done_a, perr_a, ferr_a}, 0);
    chk("rst_flags_b", {29'd0, done_b, perr_b, ferr_b}, 0);
    chk("rst_flags_c", {29'd0, done_c, perr_c, ferr_c}, 0);
    reset = 1'b0;
    idle(2 * BD);

    // 8N1 basic frame, then a frame with a low stop bit
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(2 * BD);
    chk("a_drain_a5", q_a.size(), 0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(2 * BD);
    chk("a_drain_55", q_a.size(), 0);

    // short low glitch on idle line must be rejected
    saved = nd_a;
    @(negedge clk);
    rx_a = 1'b0;
    idle(BD / 4);
    rx_a = 1'b1;
    idle(3 * BD);
    chk("glitch_no_done", nd_a, saved);
    chk("glitch_data", 32'(data_a), 32'h55);
    chk("glitch_ferr", 32'(ferr_a), 1);

    // break: line held low for many bit times yields exactly one frame
    push_exp(0, '{data: 9'h000, perr: 1'b0, ferr: 1'b1});
    @(negedge clk);
    rx_a = 1'b0;
    idle(25 * BD);
    rx_a = 1'b1;
    idle(3 * BD);
    chk("break_drain", q_a.size(), 0);
    chk("break_count", nd_a, np_a);

    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(2 * BD);
    chk("a_drain_c3", q_a.size(), 0);

    // even parity: wrong parity on 0x3C, then correct frames clear the flag
    send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1);
    idle(2 * BD);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
    idle(2 * BD);
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1);
    idle(2 * BD);
    send_frame(1, 9'h081, 8, 1'b1, 1'b1, 1, 1'b0);
    idle(2 * BD);
    chk("b_drain", q_b.size(), 0);

    // 7N2 back-to-back with no idle gap
    send_frame(2, 9'h041, 7, 1'b0, 1'b0, 2, 1'b1);
    send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 2, 1'b1);
    send_frame(2, 9'h000, 7, 1'b0, 1'b0, 2, 1'b1);
    idle(2 * BD);
    chk("c_drain", q_c.size(), 0);

    // reset in the middle of data bit 4
    partial = 8'h96;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, partial[i]);
    @(negedge clk);
    rx_a = partial[4];
    idle(BD / 2);
    reset = 1'b1;
    rx_a = 1'b1;
    idle(3);
    chk("mid_rst_data", 32'(data_a), 0);
    chk("mid_rst_flags", {29'd0, done_a, perr_a, ferr_a}, 0);
    reset = 1'b0;
    idle(15 * BD);
    chk("mid_rst_no_done", nd_a, np_a);
    send_frame(0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(2 * BD);
    chk("a_drain_0f", q_a.size(), 0);

    chk("count_a", nd_a, np_a);
    chk("count_b", nd_b, np_b);
    chk("count_c", nd_c, np_c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
